// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// Optional ALU_RETIME_EN inserts a WAIT state so the ALU gets a two-cycle path.
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_carry,
    output logic             rsp_ovf
);

`ifdef ALU_RETIME_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
`endif

    state_t           state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic             issue_id_reg, issue_id_next;
    logic [WIDTH-1:0] alu_a_reg, alu_a_next;
    logic [WIDTH-1:0] alu_b_reg, alu_b_next;
    logic [OPW-1:0]   alu_op_reg, alu_op_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0] rsp_result_reg, rsp_result_next;
    logic             rsp_zero_reg, rsp_zero_next;
    logic             rsp_neg_reg, rsp_neg_next;
    logic             rsp_carry_reg, rsp_carry_next;
    logic             rsp_ovf_reg, rsp_ovf_next;

    logic [1:0]       req_valid;
    logic             grant_en;
    logic             grant_id;
    logic [1:0]       ready_vec;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_op;
    logic             capture;

    assign req_valid = {req1_valid, req0_valid};

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant_en = 1'b0;
        grant_id = 1'b0;
        if (reset_n && (state_reg == ST_IDLE)) begin
            if (req_valid[0] && req_valid[1]) begin
                grant_en = 1'b1;
                grant_id = ~last_grant_reg;
            end else if (req_valid[0]) begin
                grant_en = 1'b1;
                grant_id = 1'b0;
            end else if (req_valid[1]) begin
                grant_en = 1'b1;
                grant_id = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = grant_en && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign sel_op = grant_id ? req1_op : req0_op;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        issue_id_next   = issue_id_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_op_next     = alu_op_reg;
        rsp_valid_next  = rsp_valid_reg;
        capture         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant_en) begin
                    alu_a_next      = sel_a;
                    alu_b_next      = sel_b;
                    alu_op_next     = sel_op;
                    issue_id_next   = grant_id;
                    last_grant_next = grant_id;
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef ALU_RETIME_EN
                state_next = ST_WAIT;
`else
                capture        = 1'b1;
                rsp_valid_next = 1'b1;
                state_next     = ST_RESP;
`endif
            end
`ifdef ALU_RETIME_EN
            ST_WAIT: begin
                capture        = 1'b1;
                rsp_valid_next = 1'b1;
                state_next     = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // Response fields only move on the capture edge so they stay stable in RESP.
    always_comb begin
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_zero_next   = rsp_zero_reg;
        rsp_neg_next    = rsp_neg_reg;
        rsp_carry_next  = rsp_carry_reg;
        rsp_ovf_next    = rsp_ovf_reg;
        if (capture) begin
            rsp_id_next     = issue_id_reg;
            rsp_result_next = alu_result;
            rsp_zero_next   = ~|alu_result;
            rsp_neg_next    = alu_result[WIDTH-1];
            rsp_carry_next  = alu_carry;
            rsp_ovf_next    = alu_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            issue_id_reg   <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_neg_reg    <= 1'b0;
            rsp_carry_reg  <= 1'b0;
            rsp_ovf_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            issue_id_reg   <= issue_id_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= alu_op_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_zero_reg   <= rsp_zero_next;
            rsp_neg_reg    <= rsp_neg_next;
            rsp_carry_reg  <= rsp_carry_next;
            rsp_ovf_reg    <= rsp_ovf_next;
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_neg    = rsp_neg_reg;
    assign rsp_carry  = rsp_carry_reg;
    assign rsp_ovf    = rsp_ovf_reg;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small add/sub/xor ALU model.
module tb_alu_share_ctrl;

`ifdef ALU_RETIME_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PERIOD = LAT + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_carry, alu_ovf;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_neg, rsp_carry, rsp_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
    );

    // ALU model: 010 add, 011 sub (carry = no borrow), 110 xor.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_op)
            3'b010: begin
                {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b011: begin
                {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b110: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                             input logic z, input logic n, input logic c, input logic o);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"}, 32'(rsp_id), 32'(id));
        chk({tag, ".result"}, rsp_result, res);
        chk({tag, ".zero"}, 32'(rsp_zero), 32'(z));
        chk({tag, ".neg"}, 32'(rsp_neg), 32'(n));
        chk({tag, ".carry"}, 32'(rsp_carry), 32'(c));
        chk({tag, ".ovf"}, 32'(rsp_ovf), 32'(o));
    endtask

    // Present one request, wait for accept, then return at the negedge where rsp_valid rises.
    task automatic do_op(input string tag, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
        int  n;
        bit  got;
        int  lat;
        req0_valid = (id == 1'b0);
        req1_valid = (id == 1'b1);
        if (id) begin req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_a = a; req0_b = b; req0_op = op; end
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1;
            else n++;
        end
        chk({tag, ".accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // scramble inputs to prove they were sampled only at accept
        req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(LAT));
        chk({tag, ".alu_a"}, alu_a, a);
        chk({tag, ".alu_b"}, alu_b, b);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu_a"}, alu_a, 32'd0);
        chk({tag, ".alu_b"}, alu_b, 32'd0);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, ".rsp_result"}, rsp_result, 32'd0);
        chk({tag, ".flags"}, {28'd0, rsp_zero, rsp_neg, rsp_carry, rsp_ovf}, 32'd0);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'd0);
    endtask

    int acc_id [3];
    int acc_cyc [3];
    int rsp_ids [3];

    initial begin
        vecs[0] = '{1'b0, 32'd5,        32'd5,        3'b011, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'd1,       3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'd1,       3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'd3,        32'd5,        3'b011, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'd1,       3'b011, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with both requesters asking: ready must stay low.
        reset_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_op = 3'b010;
        req1_valid = 1'b1; req1_a = 32'h33; req1_b = 32'h44; req1_op = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Tie held continuously: grants alternate 0,1,0 at a fixed period.
        begin
            int acc = 0;
            int nrsp = 0;
            int c = 0;
            while (nrsp < 3 && c < 40) begin
                @(negedge clk);
                if ((req0_ready || req1_ready) && acc < 3) begin
                    acc_id[acc] = req1_ready ? 1 : 0;
                    acc_cyc[acc] = c;
                    acc++;
                end
                if (rsp_valid && rsp_ready && nrsp < 3) begin
                    rsp_ids[nrsp] = int'(rsp_id);
                    nrsp++;
                end
                @(posedge clk); #1;
                if (acc == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
                c++;
            end
            chk("rr.accepts", 32'(acc), 32'd3);
            chk("rr.responses", 32'(nrsp), 32'd3);
            if (acc == 3 && nrsp == 3) begin
                chk("rr.grant0", 32'(acc_id[0]), 32'd0);
                chk("rr.grant1", 32'(acc_id[1]), 32'd1);
                chk("rr.grant2", 32'(acc_id[2]), 32'd0);
                chk("rr.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(PERIOD));
                chk("rr.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(PERIOD));
                chk("rr.rsp0", 32'(rsp_ids[0]), 32'd0);
                chk("rr.rsp1", 32'(rsp_ids[1]), 32'd1);
                chk("rr.rsp2", 32'(rsp_ids[2]), 32'd0);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Table of directed operations.
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_op(tag, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            check_rsp(tag, vecs[i].id, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].o);
            @(posedge clk); #1;
        end

        // Walking ones through the xor path.
        for (int k = 0; k < 33; k++) begin
            logic [31:0] a;
            string tag;
            a = (k < 32) ? (32'd1 << k) : 32'd0;
            tag = $sformatf("walk%0d", k);
            do_op(tag, 1'b1, a, 32'd0, 3'b110);
            check_rsp(tag, 1'b1, a, (k == 32), (k == 31), 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // Stall the response; other requester must wait until after the handshake.
        rsp_ready = 1'b0;
        do_op("stall", 1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010);
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd3; req1_op = 3'b010;
        for (int s = 0; s < 4; s++) begin
            check_rsp($sformatf("stall.c%0d", s), 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("stall.req1_ready", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check_rsp("stall.last", 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stall.req1_ready_hs", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("stall.rsp_drop", 32'(rsp_valid), 32'd0);
        chk("stall.req1_ready_after", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        begin
            int w = 0;
            while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
            chk("stall.follow_lat", 32'(w), 32'(LAT));
            check_rsp("stall.follow", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;

        // Reset asserted during ISSUE discards the operation.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 3'b010;
        begin
            int w = 0;
            while (!req0_ready && w < 10) begin @(negedge clk); w++; end
            chk("rst_mid.accept", 32'(req0_ready), 32'd1);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst_mid");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.tie_req0", 32'(req0_ready), 32'd1);
        chk("rst_mid.tie_req1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        begin
            int w = 0;
            while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
            check_rsp("rst_mid.after", 1'b0, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Controller that shares one combinational 32-bit ALU between two requesters (req0, req1).
- Arbitrates between requests round-robin.
- Registers the operands and opcode onto the ALU bus, then captures the ALU result.
- Computes the zero flag internally as the NOR of all result bits, and computes negative from the result MSB.
- Returns the result and flags on a single tagged response channel.
- Sits between the CPU datapath and issue logic and the shared ALU instance.

Parameters:
WIDTH, 32, operand/result width
OPW, 3, ALU opcode width (opcode is passed through, never decoded)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset (sampled on rising clk edge)
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a / req0_b  in  WIDTH  requester 0 operands
req0_op  in  OPW  requester 0 ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as req0, for requester 1
alu_a / alu_b  out  WIDTH  registered operands to the ALU
alu_op  out  OPW  registered opcode to the ALU
alu_result  in  WIDTH  ALU combinational result
alu_carry  in  1  ALU carry-out
alu_ovf  in  1  ALU signed overflow
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response (0 or 1)
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  1 iff rsp_result == 0
rsp_neg  out  1  rsp_result[WIDTH-1]
rsp_carry / rsp_ovf  out  1  captured alu_carry / alu_ovf

Behaviour:
- FSM states: IDLE, ISSUE, RESP (plus WAIT when ALU_RETIME_EN is defined).
- Reset (reset_n low at a rising edge, in any state including mid-operation):
  - state goes to IDLE; any in-flight or pending response is discarded;
  - all outputs go to 0: alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg, rsp_carry, rsp_ovf;
  - last_grant = 1, so requester 0 wins the first tie;
  - reqN_ready = 0 while reset_n is low.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid.
  - If both are valid, grant goes to the requester that is not last_grant.
  - reqN_ready is combinational and is 1 only for the granted requester, only in IDLE.
  - The handshake completes when valid & ready.
  - On the accept edge: latch the granted a/b/op into alu_a/alu_b/alu_op, latch the id, update last_grant, go to ISSUE.
  - With no valid request, stay in IDLE and hold all registers.
- ISSUE: alu_* are stable. At the next edge, capture into the rsp_* registers:
  - rsp_result = alu_result;
  - rsp_zero = NOR(alu_result);
  - rsp_neg = alu_result[WIDTH-1];
  - rsp_carry = alu_carry, rsp_ovf = alu_ovf.
  Then set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_valid stays 1 and all rsp_* hold stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid goes to 0 and state goes to IDLE.
  - No new request is accepted while in ISSUE or RESP (both reqN_ready = 0).
- Latency:
  - handshake in cycle N → alu_* valid in cycle N+1 → rsp_valid high in cycle N+2.
  - Peak throughput is one operation per 3 cycles (next accept in cycle N+3 if rsp_ready is high in N+2).
- Requester inputs are sampled only on the accept edge; later changes to them do not affect the operation in flight.
- alu_* hold their last operation after completion; they are not cleared.
- Ties never starve a requester: under continuous requests from both, grants strictly alternate.

Optional Feature:
ALU_RETIME_EN
- Defined: an extra WAIT state is inserted between ISSUE and capture (ISSUE→WAIT→RESP). Capture happens at the end of WAIT, giving the ALU a 2-cycle path, so rsp_valid rises at N+3 and the minimum period is 4 cycles. alu_* stay stable through ISSUE and WAIT.
- Not defined: timing is exactly as in Behaviour; the WAIT state does not exist.

Test Plan:
Bench ALU model opcodes: 010=add, 011=sub, 110=xor.
1. req0 a=5, b=5, op=011, rsp_ready=1 → rsp_valid exactly 2 cycles after handshake; rsp_id=0, rsp_result=0, rsp_zero=1, rsp_neg=0.
2. req0 and req1 valid in the same cycle, held valid → req0 served first, then req1, then req0; rsp_id sequence 0,1,0; each accept is 3 cycles apart.
3. Walking ones: req1 op=110, a=1<<k, b=0 for k=0..31 → rsp_zero=0 every time; rsp_neg=1 only for k=31; final a=0 → rsp_zero=1.
4. req0 a=0x7FFFFFFF, b=1, op=010, rsp_ready=0 for 4 cycles → rsp_result=0x80000000, rsp_neg=1, rsp_ovf=1 (model), and all rsp_* held stable; req1_valid=1 during the stall → req1_ready stays 0 until 1 cycle after the rsp handshake.
5. reset_n low in the ISSUE cycle → next cycle: state IDLE, rsp_valid=0, all outputs 0; after release, a tie grants req0.
6. With ALU_RETIME_EN defined, repeat test 1 → rsp_valid 3 cycles after handshake, same values.
